// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 DVP stream generator.
// Holds FSM state encodings, pattern mode codes and the colour-bar palette.
package ov7670_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VSYNC  = 3'd1;
    localparam state_t ST_VBACK  = 3'd2;
    localparam state_t ST_ACTIVE = 3'd3;
    localparam state_t ST_VFRONT = 3'd4;

    localparam logic [1:0] MODE_BARS  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_SOLID = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ov7670_stream_gen_pixel_gen.sv
// Combinational test-pattern source: (x, y, mode, solid_rgb) -> RGB565 pixel.
// Ports: x[8:0] pixel column, y_hi[5:0] = y[7:2], mode[1:0], solid_rgb[15:0], pix[15:0].
module ov7670_pixel_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 320
) (
    input  logic [8:0]  x,
    input  logic [5:0]  y_hi,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic [15:0] pix
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;

    always_comb begin
        // Threshold chain instead of a divider for the bar index.
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= 9'(i * BAR_W)) bar_idx = 3'(i);
        end

        pix = 16'h0000;
        unique case (mode)
            MODE_BARS:  pix = bar_colour(bar_idx);
            MODE_RAMP:  pix = {x[8:4], y_hi, x[4:0]};
            MODE_CHECK: pix = (x[4] ^ y_hi[2]) ? 16'h0000 : 16'hFFFF;
            MODE_SOLID: pix = solid_rgb;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 DVP transmitter: emits vsync/href/d frames of a test pattern on pclk_12.
// Ports: pclk_12, reset_n (sync, active low), enable, mode, solid_rgb -> vsync, href, d, busy, frame_done.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 240,
    parameter int V_FRONT  = 10
) (
    input  logic        pclk_12,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = $clog2(LINE_LEN);
    localparam int V_M1 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_M2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int VW = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   solid_q, solid_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic [VW-1:0] v_last;
    logic          h_end;
    logic          v_end;
    logic [8:0]    pix_x;
    logic [5:0]    pix_y_hi;
    logic [15:0]   pix;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        mode_d  = mode_q;
        solid_d = solid_q;

        case (state_q)
            ST_VSYNC:  v_last = VW'(V_SYNC - 1);
            ST_VBACK:  v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            ST_VFRONT: v_last = VF_LAST;
            default:   v_last = '0;
        endcase

        h_end = (h_cnt_q == H_LAST);
        v_end = (v_cnt_q == v_last);

        if (state_q == ST_IDLE) begin
            if (enable) begin
                state_d = ST_VSYNC;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        end else begin
            h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
            if (h_end) begin
                v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
                if (v_end) begin
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
        end

        // Pattern settings are frozen for the whole frame.
        if (state_d == ST_VSYNC && state_q != ST_VSYNC) begin
            mode_d  = mode;
            solid_d = solid_rgb;
        end
    end

    // Outputs are computed from next-state values so the registered
    // outputs line up with the state/counters they describe.
    assign pix_x    = 9'(h_cnt_d >> 1);
    assign pix_y_hi = 6'(v_cnt_d >> 2);

    ov7670_pixel_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel_gen (
        .x         (pix_x),
        .y_hi      (pix_y_hi),
        .mode      (mode_q),
        .solid_rgb (solid_q),
        .pix       (pix)
    );

    always_comb begin
        vsync_d      = (state_d == ST_VSYNC);
        href_d       = (state_d == ST_ACTIVE) && (h_cnt_d < H_HREF);
        d_d          = 8'h00;
        if (href_d) d_d = h_cnt_d[0] ? pix[7:0] : pix[15:8];
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_VFRONT) && (h_cnt_d == H_LAST)
                       && (v_cnt_d == VF_LAST);
    end

    always_ff @(posedge pclk_12) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            mode_q       <= mode_d;
            solid_q      <= solid_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign vsync      = vsync_q;
    assign href       = href_q;
    assign d          = d_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen with a reduced frame geometry.
// Compares every output cycle against a frame model derived from line/pixel arithmetic.
module tb_ov7670_stream_gen;

    localparam int HA = 40;
    localparam int HB = 16;
    localparam int VS = 3;
    localparam int VB = 4;
    localparam int VA = 20;
    localparam int VF = 2;
    localparam int L = 2 * HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * L;
    localparam int A0 = (VS + VB) * L;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_fail = 0;

    int    errs, vs_cnt, first_rise, pulses, bad_width, fd_cnt, fd_t;
    string first_bad;
    logic [7:0] cap [VA][2*HA];

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_ACTIVE (HA), .H_BLANK (HB), .V_SYNC (VS),
        .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF)
    ) dut (
        .pclk_12    (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [15:0] ref_pix(int m, logic [15:0] s, int x, int y);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (m)
            0: return bars[x / (HA / 8)];
            1: return 16'((((x >> 4) & 31) << 11) | (((y >> 2) & 63) << 5) | (x & 31));
            2: return (((x >> 4) ^ (y >> 4)) & 1) ? 16'h0000 : 16'hFFFF;
            default: return s;
        endcase
    endfunction

    task automatic wait_vsync(output int n);
        n = 0;
        while (vsync !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Entered at the first sample with vsync high; leaves one sample past the frame.
    task automatic check_frame(input int fm, input logic [15:0] fs, input int chg_t,
                               input logic [1:0] nm, input logic [15:0] ns, input logic nen);
        int line, h, run;
        logic ev, eh, efd;
        logic [7:0] ed;
        logic [15:0] p;
        errs = 0; vs_cnt = 0; first_rise = -1; pulses = 0;
        bad_width = 0; fd_cnt = 0; fd_t = -1; run = 0; first_bad = "";
        for (int i = 0; i < VA; i++)
            for (int j = 0; j < 2 * HA; j++) cap[i][j] = 'x;
        for (int t = 0; t < FRAME; t++) begin
            line = t / L;
            h = t % L;
            ev = (line < VS);
            eh = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
            ed = 8'h00;
            if (eh) begin
                p = ref_pix(fm, fs, h / 2, line - VS - VB);
                ed = (h % 2 == 1) ? p[7:0] : p[15:8];
            end
            efd = (t == FRAME - 1);
            if (vsync !== ev || href !== eh || d !== ed || busy !== 1'b1
                || frame_done !== efd) begin
                if (errs == 0)
                    first_bad = $sformatf("t=%0d vs=%b/%b hr=%b/%b d=%h/%h busy=%b fd=%b/%b",
                                          t, vsync, ev, href, eh, d, ed, busy,
                                          frame_done, efd);
                errs++;
            end
            if (vsync === 1'b1) vs_cnt++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_t = t;
            end
            if (href === 1'b1) begin
                if (run == 0 && first_rise < 0) first_rise = t;
                run++;
                if (eh) cap[line - VS - VB][h] = d;
            end else if (run != 0) begin
                pulses++;
                if (run != 2 * HA) bad_width++;
                run = 0;
            end
            if (t == chg_t) begin
                mode = nm;
                solid_rgb = ns;
                enable = nen;
            end
            @(negedge clk);
        end
        if (run != 0) begin
            pulses++;
            if (run != 2 * HA) bad_width++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", vsync); end
        n_checks++;
        if (href !== 1'b0) begin n_fail++; $display("FAIL reset_href: got %b want 0", href); end
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_d: got %h want 00", d); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vsync !== 1'b0 || href !== 1'b0 || busy !== 1'b0 || d !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_bars();
        int n;
        mode = 2'd0;
        solid_rgb = 16'($urandom);
        enable = 1'b1;
        @(negedge clk);
        wait_vsync(n);
        n_checks++;
        if (n != 0) begin n_fail++; $display("FAIL bars_start_latency: got %0d extra cycles want 0", n); end
        check_frame(0, 16'h0, $urandom_range(0, FRAME - 2), 2'd2, 16'($urandom), 1'b1);
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL bars_stream: got %0d bad cycles want 0, first %s", errs, first_bad); end
        n_checks++;
        if (vs_cnt != VS * L) begin n_fail++; $display("FAIL bars_vsync_len: got %0d want %0d", vs_cnt, VS * L); end
        n_checks++;
        if (first_rise != A0) begin n_fail++; $display("FAIL bars_first_href: got %0d want %0d", first_rise, A0); end
        n_checks++;
        if (pulses != VA || bad_width != 0) begin
            n_fail++; $display("FAIL bars_href_pulses: got %0d (bad widths %0d) want %0d", pulses, bad_width, VA);
        end
        n_checks++;
        if ({cap[0][0], cap[0][1]} !== 16'hFFFF) begin
            n_fail++; $display("FAIL bars_first_bytes: got %h%h want FFFF", cap[0][0], cap[0][1]);
        end
        n_checks++;
        if ({cap[0][10], cap[0][11]} !== 16'hFFE0) begin
            n_fail++; $display("FAIL bars_bar1_bytes: got %h%h want FFE0", cap[0][10], cap[0][11]);
        end
        n_checks++;
        if ({cap[0][78], cap[0][79]} !== 16'h0000) begin
            n_fail++; $display("FAIL bars_last_bytes: got %h%h want 0000", cap[0][78], cap[0][79]);
        end
        n_checks++;
        if (fd_cnt != 1 || fd_t != FRAME - 1) begin
            n_fail++; $display("FAIL bars_frame_done: got %0d pulses at %0d want 1 at %0d", fd_cnt, fd_t, FRAME - 1);
        end
        n_checks++;
        if (vsync !== 1'b1) begin n_fail++; $display("FAIL bars_back_to_back_vsync: got %b want 1", vsync); end
    endtask

    task automatic test_checker();
        check_frame(2, 16'h0, $urandom_range(0, FRAME - 2), 2'd3, 16'h1234, 1'b1);
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL checker_stream: got %0d bad cycles want 0, first %s", errs, first_bad); end
        n_checks++;
        if ({cap[0][0], cap[0][1]} !== 16'hFFFF) begin
            n_fail++; $display("FAIL checker_0_0: got %h%h want FFFF", cap[0][0], cap[0][1]);
        end
        n_checks++;
        if ({cap[0][32], cap[0][33]} !== 16'h0000) begin
            n_fail++; $display("FAIL checker_16_0: got %h%h want 0000", cap[0][32], cap[0][33]);
        end
        n_checks++;
        if ({cap[16][32], cap[16][33]} !== 16'hFFFF) begin
            n_fail++; $display("FAIL checker_16_16: got %h%h want FFFF", cap[16][32], cap[16][33]);
        end
        n_checks++;
        if (fd_cnt != 1 || vsync !== 1'b1) begin
            n_fail++; $display("FAIL checker_period: got %0d pulses next vsync %b want 1 and 1", fd_cnt, vsync);
        end
    endtask

    task automatic test_solid();
        int bad = 0;
        check_frame(3, 16'h1234, $urandom_range(0, FRAME - 2), 2'd0, 16'($urandom), 1'b1);
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++)
                if ({cap[y][2*x], cap[y][2*x+1]} !== 16'h1234) bad++;
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL solid_stream: got %0d bad cycles want 0, first %s", errs, first_bad); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL solid_pairs: got %0d bad pairs want 0", bad); end
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        check_frame(0, 16'h0, $urandom_range(A0, A0 + VA * L - 1), 2'd2, 16'($urandom), 1'b0);
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL drop_stream: got %0d bad cycles want 0, first %s", errs, first_bad); end
        n_checks++;
        if (fd_cnt != 1) begin n_fail++; $display("FAIL drop_frame_done: got %0d want 1", fd_cnt); end
        n_checks++;
        if (vsync !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_to_idle: got vsync %b busy %b want 0 0", vsync, busy);
        end
        for (int i = 0; i < 3 * L; i++) begin
            @(negedge clk);
            if (vsync !== 1'b0 || busy !== 1'b0 || href !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL drop_stays_idle: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_ramp();
        int n;
        mode = 2'd1;
        solid_rgb = 16'($urandom);
        enable = 1'b1;
        @(negedge clk);
        wait_vsync(n);
        check_frame(1, 16'h0, $urandom_range(0, FRAME - 2), 2'($urandom), 16'($urandom), 1'b0);
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL ramp_stream: got %0d bad cycles want 0, first %s", errs, first_bad); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        wait_vsync(n);
        repeat (A0 + 2 * L + 30) @(negedge clk);
        n_checks++;
        if (href !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_href: got %b want 1", href); end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vsync !== 1'b0 || href !== 1'b0 || d !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got vs %b hr %b d %h busy %b fd %b want all 0",
                     vsync, href, d, busy, frame_done);
        end
        reset_n = 1'b1;
        @(negedge clk);
        wait_vsync(n);
        n_checks++;
        if (n != 0) begin n_fail++; $display("FAIL midreset_restart: got %0d extra cycles want 0", n); end
        check_frame(0, 16'h0, $urandom_range(A0, FRAME - 2), 2'd0, 16'h0, 1'b0);
        n_checks++;
        if (errs != 0 || vs_cnt != VS * L || first_rise != A0 || pulses != VA) begin
            n_fail++;
            $display("FAIL midreset_rerun: got errs %0d vs %0d rise %0d pulses %0d want 0 %0d %0d %0d, first %s",
                     errs, vs_cnt, first_rise, pulses, VS * L, A0, VA, first_bad);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_bars();
        test_checker();
        test_solid();
        test_enable_drop();
        test_ramp();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
